// File: rtl/shift_rr_arbiter_pkg.sv
// rtl/shift_rr_arbiter_pkg.sv - shared types and constants for the shift round-robin arbiter
package shift_rr_arbiter_pkg;

  typedef enum logic {SHIFT_LEFT = 1'b0, SHIFT_RIGHT = 1'b1} shift_dir_t;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

  localparam int STALL_CNT_WIDTH = 16;

endpackage

// File: rtl/shift_rr_arbiter_rr_grant.sv
// rtl/shift_rr_arbiter_rr_grant.sv - combinational round-robin picker starting at ptr_i
module rr_grant #(
  parameter int nreq = 2
) (
  input  logic [nreq-1:0]         req_i,
  input  logic [$clog2(nreq)-1:0] ptr_i,
  input  logic                    enable_i,
  output logic [nreq-1:0]         grant_o,
  output logic [$clog2(nreq)-1:0] grant_idx_o,
  output logic                    any_grant_o
);

  always_comb begin
    int idx;
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    idx         = 0;
    if (enable_i) begin
      // Scan from the farthest offset down so the nearest request to ptr wins.
      for (int k = nreq - 1; k >= 0; k--) begin
        idx = int'(ptr_i) + k;
        if (idx >= nreq) idx = idx - nreq;
        if (req_i[idx]) begin
          any_grant_o = 1'b1;
          grant_idx_o = idx[$clog2(nreq)-1:0];
        end
      end
      if (any_grant_o) grant_o[grant_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/shift_rr_arbiter.sv
// rtl/shift_rr_arbiter.sv - round-robin sharing of one logical shifter with a registered response slot
// Optional stall counter output enabled by SHIFT_RR_ARBITER_STALL_CNT_EN.
module shift_rr_arbiter
  import shift_rr_arbiter_pkg::*;
#(
  parameter int width = 8,
  parameter int nreq  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [nreq-1:0]                 req_valid,
  output logic [nreq-1:0]                 req_ready,
  input  logic [nreq*width-1:0]           req_bits,
  input  logic [nreq*$clog2(width)-1:0]   req_shift,
  input  logic [nreq-1:0]                 req_dir,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [width-1:0]                rsp_bits,
  output logic [$clog2(nreq)-1:0]         rsp_id
`ifdef SHIFT_RR_ARBITER_STALL_CNT_EN
  ,output logic [STALL_CNT_WIDTH-1:0]     stall_cnt
`endif
);

  localparam int SW = $clog2(width);
  localparam int IW = $clog2(nreq);

  slot_state_t      slot_q, slot_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [width-1:0] bits_q, bits_d;
  logic [IW-1:0]    id_q, id_d;

  logic             can_accept;
  logic [nreq-1:0]  grant;
  logic [IW-1:0]    grant_idx;
  logic             any_grant;

  logic [width-1:0] cmd_bits;
  logic [SW-1:0]    cmd_shift;
  shift_dir_t       cmd_dir;
  logic [width-1:0] shifted;

  assign can_accept = !rst && (slot_q == SLOT_EMPTY || rsp_ready);

  rr_grant #(.nreq(nreq)) u_rr_grant (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .enable_i    (can_accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  assign req_ready = grant;

  assign cmd_bits  = req_bits[grant_idx*width +: width];
  assign cmd_shift = req_shift[grant_idx*SW +: SW];
  assign cmd_dir   = shift_dir_t'(req_dir[grant_idx]);

  // Amounts at or beyond width only exist for non-power-of-two widths; they flush to zero.
  always_comb begin
    shifted = '0;
    if (32'(cmd_shift) < 32'(width)) begin
      if (cmd_dir == SHIFT_RIGHT) shifted = cmd_bits >> cmd_shift;
      else                        shifted = cmd_bits << cmd_shift;
    end
  end

  always_comb begin
    slot_d = slot_q;
    ptr_d  = ptr_q;
    bits_d = bits_q;
    id_d   = id_q;
    if (any_grant) begin
      slot_d = SLOT_FULL;
      bits_d = shifted;
      id_d   = grant_idx;
      if (32'(grant_idx) == 32'(nreq - 1)) ptr_d = '0;
      else                                 ptr_d = grant_idx + IW'(1);
    end else if (slot_q == SLOT_FULL && rsp_ready) begin
      slot_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= SLOT_EMPTY;
      ptr_q  <= '0;
      bits_q <= '0;
      id_q   <= '0;
    end else begin
      slot_q <= slot_d;
      ptr_q  <= ptr_d;
      bits_q <= bits_d;
      id_q   <= id_d;
    end
  end

  assign rsp_valid = (slot_q == SLOT_FULL);
  assign rsp_bits  = bits_q;
  assign rsp_id    = id_q;

`ifdef SHIFT_RR_ARBITER_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (|req_valid && !any_grant && stall_q != '1) stall_d = stall_q + STALL_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_shift_rr_arbiter.sv
// tb/tb_shift_rr_arbiter.sv - scoreboard bench for shift_rr_arbiter with a behavioural reference model
module tb_shift_rr_arbiter;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int SW = 3;
  localparam int IW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_dir;
  logic [N*W-1:0]    req_bits;
  logic [N*SW-1:0]   req_shift;
  logic              rsp_valid, rsp_ready;
  logic [W-1:0]      rsp_bits;
  logic [IW-1:0]     rsp_id;
`ifdef SHIFT_RR_ARBITER_STALL_CNT_EN
  logic [15:0]       stall_cnt, stall6;
`endif

  shift_rr_arbiter #(.width(W), .nreq(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_bits  (req_bits),
    .req_shift (req_shift),
    .req_dir   (req_dir),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_bits  (rsp_bits),
    .rsp_id    (rsp_id)
`ifdef SHIFT_RR_ARBITER_STALL_CNT_EN
    ,.stall_cnt (stall_cnt)
`endif
  );

  logic        r6_rst, r6_rsp_ready, r6_rsp_valid;
  logic [1:0]  r6_valid, r6_ready, r6_dir;
  logic [11:0] r6_bits;
  logic [5:0]  r6_shift;
  logic [5:0]  r6_rsp_bits;
  logic        r6_rsp_id;

  shift_rr_arbiter #(.width(6), .nreq(2)) dut6 (
    .clk       (clk),
    .rst       (r6_rst),
    .req_valid (r6_valid),
    .req_ready (r6_ready),
    .req_bits  (r6_bits),
    .req_shift (r6_shift),
    .req_dir   (r6_dir),
    .rsp_valid (r6_rsp_valid),
    .rsp_ready (r6_rsp_ready),
    .rsp_bits  (r6_rsp_bits),
    .rsp_id    (r6_rsp_id)
`ifdef SHIFT_RR_ARBITER_STALL_CNT_EN
    ,.stall_cnt (stall6)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: logical shift expressed as multiply/divide by powers of two.
  function automatic int ref_shift(input int b, input int sh, input bit right, input int w);
    if (sh >= w) return 0;
    if (right) return b / (1 << sh);
    return (b * (1 << sh)) % (1 << w);
  endfunction

  typedef struct {int bits; int id;} exp_t;
  exp_t sb[$];

  int       c_bits[N];
  int       c_sh[N];
  bit       c_dir[N];
  bit       m_full = 1'b0;
  int       m_ptr  = 0;
  logic [N-1:0] exp_ready = '0;
  bit       exp_valid = 1'b0;
  bit       mon_en = 1'b0;
  int       last_grant;

  task automatic drive_cycle(input bit r, input logic [N-1:0] v, input bit rr);
    int g;
    g = -1;
    rst = r; req_valid = v; rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_bits[i*W +: W]   = W'(c_bits[i]);
      req_shift[i*SW +: SW] = SW'(c_sh[i]);
      req_dir[i]           = c_dir[i];
    end
    exp_valid = m_full;
    exp_ready = '0;
    if (!r && (!m_full || rr)) begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (v[j] && g < 0) g = j;
      end
    end
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      sb.push_back(exp_t'{ref_shift(c_bits[g], c_sh[g], c_dir[g], W), g});
    end
    last_grant = g;
    @(posedge clk); #1;
    if (r) begin
      m_full = 1'b0; m_ptr = 0; sb.delete();
    end else if (g >= 0) begin
      m_full = 1'b1; m_ptr = (g + 1) % N;
    end else if (m_full && rr) begin
      m_full = 1'b0;
    end
  endtask

  task automatic set_cmd(input int i, input int b, input int sh, input bit right);
    c_bits[i] = b; c_sh[i] = sh; c_dir[i] = right;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_underflow: response with no expected entry at %0t", $time);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_bits", 32'(rsp_bits), 32'(e.bits));
            check("rsp_id", 32'(rsp_id), 32'(e.id));
          end
        end
      end
    end
  end

  initial begin
    bit held[N];
    logic [N-1:0] v;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_bits = '0; req_shift = '0; req_dir = '0;
    r6_rst = 1'b1; r6_valid = '0; r6_rsp_ready = 1'b1; r6_bits = '0; r6_shift = '0; r6_dir = '0;
    set_cmd(0, 8'h11, 1, 1'b0);
    set_cmd(1, 8'h22, 2, 1'b1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Reset held with both requesters valid.
    repeat (3) drive_cycle(1'b1, 2'b11, 1'b1);
    check("reset_bits", 32'(rsp_bits), 32'h0);
    check("reset_id", 32'(rsp_id), 32'h0);
`ifdef SHIFT_RR_ARBITER_STALL_CNT_EN
    check("reset_stall", 32'(stall_cnt), 32'h0);
`endif

    // First grant after reset goes to requester 0.
    set_cmd(0, 8'h81, 1, 1'b0);
    drive_cycle(1'b0, 2'b11, 1'b1);
    check("single_bits", 32'(rsp_bits), 32'h02);
    check("single_id", 32'(rsp_id), 32'h0);

    // Contention, aligned so requester 0 leads.
    set_cmd(0, 8'h0F, 4, 1'b0);
    set_cmd(1, 8'h80, 3, 1'b1);
    drive_cycle(1'b0, 2'b10, 1'b1);
    for (int k = 0; k < 6; k++) begin
      drive_cycle(1'b0, 2'b11, 1'b1);
      check("cont_id", 32'(rsp_id), 32'(k % 2));
      check("cont_bits", 32'(rsp_bits), (k % 2) ? 32'h10 : 32'hF0);
    end

    // Backpressure: slot holds 0x10/id1.
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, 2'b11, 1'b0);
      check("hold_bits", 32'(rsp_bits), 32'h10);
      check("hold_id", 32'(rsp_id), 32'h1);
    end
`ifdef SHIFT_RR_ARBITER_STALL_CNT_EN
    check("stall_after_bp", 32'(stall_cnt), 32'd4);
`endif
    drive_cycle(1'b0, 2'b11, 1'b1);
    check("bp_release_bits", 32'(rsp_bits), 32'hF0);
    check("bp_release_id", 32'(rsp_id), 32'h0);

    // Shift boundaries.
    set_cmd(0, 8'hA5, 0, 1'b0);
    drive_cycle(1'b0, 2'b01, 1'b1);
    check("shl0", 32'(rsp_bits), 32'hA5);
    set_cmd(0, 8'hA5, 7, 1'b0);
    drive_cycle(1'b0, 2'b01, 1'b1);
    check("shl7", 32'(rsp_bits), 32'h80);
    set_cmd(0, 8'hA5, 7, 1'b1);
    drive_cycle(1'b0, 2'b01, 1'b1);
    check("shr7", 32'(rsp_bits), 32'h01);

    // Reset while full with ptr=1.
    drive_cycle(1'b0, 2'b01, 1'b1);
    drive_cycle(1'b1, 2'b11, 1'b0);
    check("midrst_valid", 32'(rsp_valid), 32'h0);
`ifdef SHIFT_RR_ARBITER_STALL_CNT_EN
    check("midrst_stall", 32'(stall_cnt), 32'h0);
`endif
    drive_cycle(1'b0, 2'b11, 1'b1);
    check("midrst_first_id", 32'(rsp_id), 32'h0);

    // Randomized traffic; ungranted commands are held stable.
    for (int i = 0; i < N; i++) held[i] = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (held[i]) v[i] = 1'b1;
        else begin
          v[i] = ($urandom_range(0, 99) < 60);
          set_cmd(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
        end
      end
      drive_cycle(($urandom_range(0, 199) == 0), v, ($urandom_range(0, 99) < 70));
      for (int i = 0; i < N; i++) held[i] = v[i] && (last_grant != i);
    end
    drive_cycle(1'b0, 2'b00, 1'b1);
    drive_cycle(1'b0, 2'b00, 1'b1);
    check("sb_drained", 32'(sb.size()), 32'h0);
    mon_en = 1'b0;

    // Width 6: amounts at or past the width flush to zero.
    r6_rst = 1'b0;
    r6_valid = 2'b01; r6_bits[5:0] = 6'h3F; r6_shift[2:0] = 3'd6; r6_dir[0] = 1'b0;
    @(posedge clk); #1;
    check("w6_valid", 32'(r6_rsp_valid), 32'h1);
    check("w6_shl6", 32'(r6_rsp_bits), 32'h0);
    r6_shift[2:0] = 3'd7; r6_dir[0] = 1'b1;
    @(posedge clk); #1;
    check("w6_shr7", 32'(r6_rsp_bits), 32'h0);
    r6_shift[2:0] = 3'd5; r6_dir[0] = 1'b0;
    @(posedge clk); #1;
    check("w6_shl5", 32'(r6_rsp_bits), 32'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
